// File: rtl/sha1_msg_loader.sv
// Packs a byte stream into little-endian words, writes them to DPSRAM port A and starts the SHA-1 core.
// Define SHA1_LOADER_PAD_EN to also write the SHA-1 padding and length field to memory.
module sha1_msg_loader #(
  parameter int unsigned MAX_BYTES = 65532,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              load_start,
  input  logic [31:0]       load_addr,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic [31:0]       port_A_data_in,
  output logic              port_A_we,
  output logic              hash_start,
  output logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  output logic [31:0]       pad_len,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam logic [2:0] S_START = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]  state;
  logic [31:0] base;
  logic [31:0] cnt;
  logic [31:0] lane_buf;
  logic [29:0] widx;
  logic [1:0]  lane;
  logic        accept;
  logic        ovf;
  logic [31:0] merged;
  logic [31:0] addr_sum;

  // Padded length: smallest 64n+56 that leaves room for the 0x80 marker.
  function automatic logic [31:0] pad_of(input logic [31:0] c);
    logic [31:0] r;
    r = c + 32'd1;
    if (r[5:0] != 6'd0 && r[5:0] <= 6'd56)
      pad_of = {c[31:6], 6'd0} + 32'd56;
    else
      pad_of = {c[31:6], 6'd0} + 32'd120;
  endfunction

`ifdef SHA1_LOADER_PAD_EN
  function automatic logic [31:0] bswap(input logic [31:0] v);
    bswap = {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction
`endif

  assign port_A_clk = clk;
  assign lane       = cnt[1:0];
  assign s_ready    = (state == S_LOAD) || (state == S_DRAIN);
  assign busy       = (state != S_IDLE);
  assign hash_start = (state == S_START);
  assign accept     = s_valid && s_ready;
  assign merged     = lane_buf | ({24'd0, s_data} << {lane, 3'b000});
  assign addr_sum   = base + {widx, 2'b00};

`ifdef SHA1_LOADER_PAD_EN
  assign ovf = (pad_of(cnt + 32'd1) + 32'd8) > 32'(MAX_BYTES);
`else
  assign ovf = (cnt == 32'(MAX_BYTES));
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state          <= S_IDLE;
      base           <= '0;
      cnt            <= '0;
      lane_buf       <= '0;
      widx           <= '0;
      port_A_we      <= 1'b0;
      port_A_addr    <= '0;
      port_A_data_in <= '0;
      message_addr   <= '0;
      message_size   <= '0;
      pad_len        <= '0;
      err            <= 1'b0;
    end else begin
      port_A_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            base     <= load_addr;
            cnt      <= '0;
            lane_buf <= '0;
            widx     <= '0;
            err      <= (load_addr[1:0] != 2'b00);
            state    <= (load_addr[1:0] != 2'b00) ? S_DRAIN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (ovf) begin
              // An overflowing byte that is also the last one already ends the drain.
              err   <= 1'b1;
              state <= s_last ? S_IDLE : S_DRAIN;
            end else begin
              cnt <= cnt + 32'd1;
              if (lane == 2'd3) begin
                port_A_we      <= 1'b1;
                port_A_addr    <= addr_sum[ADDR_W-1:0];
                port_A_data_in <= merged;
                lane_buf       <= '0;
                widx           <= widx + 30'd1;
              end else begin
                lane_buf <= merged;
              end
              if (s_last) state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          message_addr <= base;
          message_size <= cnt;
          pad_len      <= pad_of(cnt);
`ifdef SHA1_LOADER_PAD_EN
          state <= S_PAD;
`else
          if (lane != 2'd0) begin
            port_A_we      <= 1'b1;
            port_A_addr    <= addr_sum[ADDR_W-1:0];
            port_A_data_in <= lane_buf;
          end
          state <= S_START;
`endif
        end
`ifdef SHA1_LOADER_PAD_EN
        S_PAD: begin
          // widx starts at cnt/4, so the first pad word carries any partial message word.
          port_A_we   <= 1'b1;
          port_A_addr <= addr_sum[ADDR_W-1:0];
          widx        <= widx + 30'd1;
          if (widx == cnt[31:2])
            port_A_data_in <= lane_buf | (32'h80 << {lane, 3'b000});
          else if (widx == pad_len[31:2])
            port_A_data_in <= bswap(cnt >> 29);
          else if (widx == pad_len[31:2] + 30'd1) begin
            port_A_data_in <= bswap(cnt << 3);
            state          <= S_START;
          end else
            port_A_data_in <= '0;
        end
`endif
        S_START: state <= S_IDLE;
        S_DRAIN: if (accept && s_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
